// File: rtl/ip_loader.sv
// Instruction-store loader: assembles big-endian words from a byte stream into a
// 64 x 32-bit store, with a combinational fetch port that stays live during loads.
module ip_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  load_len,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        busy,
  output logic        done,
  input  logic [31:0] a,
  output logic [31:0] inst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] store [64];
  logic [6:0]  len_q;
  logic [5:0]  wr_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_q;
  logic        accept;
  logic        last_word;
  logic        unused_a;

  assign accept    = byte_ready & byte_valid;
  // Compare in 7 bits so a 64-word load terminates after index 63.
  assign last_word = (({1'b0, wr_idx} + 7'd1) == len_q);
  assign inst      = store[a[7:2]];
  assign unused_a  = ^{a[31:8], a[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    byte_ready = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (load_len == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        byte_ready = 1'b1;
        if (byte_valid && (byte_cnt == 2'd3)) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        state_nx = last_word ? DONE : RECV;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      wr_idx   <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      for (int unsigned i = 0; i < 64; i++) begin
        store[i] <= '1;
      end
    end else begin
      if ((state == IDLE) && start && (load_len != '0)) begin
        len_q    <= load_len;
        wr_idx   <= '0;
        byte_cnt <= '0;
      end
      if (accept) begin
        word_q   <= {word_q[23:0], byte_in};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == WRITE) begin
        store[wr_idx] <= word_q;
        wr_idx        <= wr_idx + 6'd1;
        byte_cnt      <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ip_loader.sv
// Randomized bench for ip_loader with a transaction-level store/timing model.
module tb_ip_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  load_len = '0;
  logic [7:0]  byte_in = '0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic [31:0] a = '0;
  logic [31:0] inst;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [64];
  logic [31:0] wv [64];

  ip_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_len  (load_len),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .busy      (busy),
    .done      (done),
    .a         (a),
    .inst      (inst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) model[i] = 32'hFFFF_FFFF;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 64; i++) begin
      a = {$urandom_range(0, 32'h00FF_FFFF)} << 8;
      a[7:2] = i[5:0];
      a[1:0] = 2'($urandom);
      #1;
      check(tag, inst, model[i]);
    end
    a = 32'h0000_0100;
    #1;
    check({tag, "_alias100"}, inst, model[0]);
  endtask

  // Drives one load. vmode: 0 valid always 1, 1 toggling 1/0, 2 random.
  task automatic run_load(input int len, input int vmode, input bit inject);
    int wd, nb, done_seen, pulses, c;
    bit gap, dn, v;
    logic [31:0] cur;
    check("pre_idle_busy", 32'(busy), 32'd0);
    start = 1'b1;
    load_len = len[6:0];
    byte_valid = 1'($urandom);
    byte_in = 8'($urandom);
    wd = 0; nb = 0; gap = 0; dn = (len == 0);
    done_seen = -1; pulses = 0;
    for (c = 1; c < 3000; c++) begin
      tick();
      start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        if (done_seen < 0) done_seen = c;
      end
      check("busy", 32'(busy), 32'd1);
      check("byte_ready", 32'(byte_ready), 32'(!gap && !dn));
      check("done", 32'(done), 32'(dn));
      a = $urandom;
      #1;
      check("fetch_live", inst, model[a[7:2]]);
      case (vmode)
        0: v = 1'b1;
        1: v = c[0];
        default: v = 1'($urandom);
      endcase
      if (inject) begin
        start = 1'($urandom);
        load_len = 7'($urandom);
      end
      byte_valid = v;
      byte_in = 8'($urandom);
      if (!gap && !dn && wd < 64) begin
        cur = wv[wd];
        byte_in = cur[31 - 8*nb -: 8];
      end
      if (dn) break;
      if (gap) begin
        model[wd] = wv[wd];
        wd++;
        gap = 0;
        dn = (wd == len);
      end else if (v) begin
        nb++;
        if (nb == 4) begin
          nb = 0;
          gap = 1;
        end
      end
    end
    check("load_bounded", 32'(c < 3000), 32'd1);
    tick();
    start = 1'b0;
    byte_valid = 1'b0;
    check("post_busy", 32'(busy), 32'd0);
    check("post_done", 32'(done), 32'd0);
    check("done_pulses", pulses, 32'd1);
    if (vmode == 0) check("done_cycle", done_seen, 5*len + 1);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    start = 1'b1;
    load_len = 7'd5;
    byte_valid = 1'b1;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    sweep("rst_sweep");
    tick();

    // Directed two-word load.
    wv[0] = 32'h2023_0000;
    wv[1] = 32'h1421_0001;
    run_load(2, 0, 0);
    a = 32'h0; #1; check("d2_a0", inst, 32'h2023_0000);
    a = 32'h4; #1; check("d2_a4", inst, 32'h1421_0001);
    a = 32'h8; #1; check("d2_a8", inst, 32'hFFFF_FFFF);

    // One word with toggling valid.
    wv[0] = $urandom;
    run_load(1, 1, 0);
    sweep("tog_sweep");

    // Full 64-word load with incrementing values and start noise.
    for (int i = 0; i < 64; i++) wv[i] = i;
    run_load(64, 0, 1);
    sweep("full_sweep");

    // Zero-length load leaves the store untouched.
    run_load(0, 0, 0);
    sweep("zero_sweep");

    // Reset during the WRITE cycle of word 1.
    wv[0] = $urandom;
    wv[1] = $urandom;
    start = 1'b1;
    load_len = 7'd3;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      byte_valid = 1'b1;
      if (c <= 4) byte_in = wv[0][31 - 8*(c-1) -: 8];
      else if (c >= 6 && c <= 9) byte_in = wv[1][31 - 8*(c-6) -: 8];
      if (c == 6) begin
        a = 32'h0; #1;
        check("rw_word0_written", inst, wv[0]);
      end
    end
    check("rw_in_write_ready", 32'(byte_ready), 32'd0);
    check("rw_in_write_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    tick();
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_ready", 32'(byte_ready), 32'd0);
    check("rw_done", 32'(done), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    byte_valid = 1'b0;
    model_reset();
    sweep("rw_sweep");
    tick();
    check("rw_idle", 32'(busy), 32'd0);

    // Random loads.
    for (int k = 0; k < 5; k++) begin
      int len;
      len = $urandom_range(1, 64);
      for (int i = 0; i < 64; i++) wv[i] = $urandom;
      run_load(len, $urandom_range(0, 2), 1'($urandom));
      sweep("rand_sweep");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
